// File: rtl/toy_commit_regfile.sv
// Committed (architectural) register map for int and fp files. Commits update the
// map, free the previously committed physical ids one cycle later, and flag cancel edges.
module toy_commit_regfile #(
    parameter int COMMIT_NUM       = 4,
    parameter int ARCH_ENTRY_NUM   = 32,
    parameter int PHY_REG_ID_WIDTH = 7
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [COMMIT_NUM-1:0]                    v_int_commit_en,
    input  logic [COMMIT_NUM-1:0]                    v_fp_commit_en,
    input  logic [5*COMMIT_NUM-1:0]                  v_commit_rd_index,
    input  logic [PHY_REG_ID_WIDTH*COMMIT_NUM-1:0]   v_int_commit_phy_id,
    input  logic [PHY_REG_ID_WIDTH*COMMIT_NUM-1:0]   v_fp_commit_phy_id,
    input  logic                                     cancel_en,
    output logic [PHY_REG_ID_WIDTH*ARCH_ENTRY_NUM-1:0] v_int_backup_phy_id,
    output logic [PHY_REG_ID_WIDTH*ARCH_ENTRY_NUM-1:0] v_fp_backup_phy_id,
    output logic                                     cancel_edge_en_d,
    output logic [COMMIT_NUM-1:0]                    v_int_release_vld,
    output logic [COMMIT_NUM-1:0]                    v_fp_release_vld,
    output logic [PHY_REG_ID_WIDTH*COMMIT_NUM-1:0]   v_int_release_id,
    output logic [PHY_REG_ID_WIDTH*COMMIT_NUM-1:0]   v_fp_release_id
);

    localparam int IDX_W = 5;
    localparam int PW    = PHY_REG_ID_WIDTH;

    logic [PW-1:0]         r_int_table [ARCH_ENTRY_NUM];
    logic [PW-1:0]         r_fp_table  [ARCH_ENTRY_NUM];
    logic [PW-1:0]         w_int_next  [ARCH_ENTRY_NUM];
    logic [PW-1:0]         w_fp_next   [ARCH_ENTRY_NUM];

    logic [IDX_W-1:0]      w_idx       [COMMIT_NUM];
    logic [PW-1:0]         w_int_phy   [COMMIT_NUM];
    logic [PW-1:0]         w_fp_phy    [COMMIT_NUM];
    logic [PW-1:0]         w_int_rel   [COMMIT_NUM];
    logic [PW-1:0]         w_fp_rel    [COMMIT_NUM];
    logic [COMMIT_NUM-1:0] w_int_en;

    logic [COMMIT_NUM-1:0] r_int_rel_vld;
    logic [COMMIT_NUM-1:0] r_fp_rel_vld;
    logic [PW-1:0]         r_int_rel_id [COMMIT_NUM];
    logic [PW-1:0]         r_fp_rel_id  [COMMIT_NUM];
    logic                  r_cancel_d;
    logic                  r_cancel_edge;

    genvar g;
    generate
        for (g = 0; g < COMMIT_NUM; g++) begin : g_slot
            assign w_idx[g]     = v_commit_rd_index[g*IDX_W +: IDX_W];
            assign w_int_phy[g] = v_int_commit_phy_id[g*PW +: PW];
            assign w_fp_phy[g]  = v_fp_commit_phy_id[g*PW +: PW];
            // x0 is hardwired zero, so int commits to it are dropped entirely.
            assign w_int_en[g]  = v_int_commit_en[g] && (w_idx[g] != '0);
            assign v_int_release_id[g*PW +: PW] = r_int_rel_id[g];
            assign v_fp_release_id[g*PW +: PW]  = r_fp_rel_id[g];
        end
        for (g = 0; g < ARCH_ENTRY_NUM; g++) begin : g_entry
            assign v_int_backup_phy_id[g*PW +: PW] = r_int_table[g];
            assign v_fp_backup_phy_id[g*PW +: PW]  = r_fp_table[g];
        end
    endgenerate

    // Later slots overwrite earlier ones so the youngest commit wins.
    always_comb begin
        for (int j = 0; j < ARCH_ENTRY_NUM; j++) begin
            w_int_next[j] = r_int_table[j];
            w_fp_next[j]  = r_fp_table[j];
            for (int i = 0; i < COMMIT_NUM; i++) begin
                if (w_int_en[i] && (w_idx[i] == IDX_W'(j)))
                    w_int_next[j] = w_int_phy[i];
                if (v_fp_commit_en[i] && (w_idx[i] == IDX_W'(j)))
                    w_fp_next[j] = w_fp_phy[i];
            end
        end
    end

    // Freed id is the mapping this slot displaces: an older same-cycle slot if any,
    // otherwise the committed table entry.
    always_comb begin
        for (int i = 0; i < COMMIT_NUM; i++) begin
            w_int_rel[i] = '0;
            w_fp_rel[i]  = '0;
            for (int j = 0; j < ARCH_ENTRY_NUM; j++) begin
                if (w_idx[i] == IDX_W'(j)) begin
                    w_int_rel[i] = r_int_table[j];
                    w_fp_rel[i]  = r_fp_table[j];
                end
            end
            for (int k = 0; k < i; k++) begin
                if (w_int_en[k] && (w_idx[k] == w_idx[i]))
                    w_int_rel[i] = w_int_phy[k];
                if (v_fp_commit_en[k] && (w_idx[k] == w_idx[i]))
                    w_fp_rel[i] = w_fp_phy[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < ARCH_ENTRY_NUM; j++) begin
                r_int_table[j] <= PW'(j);
                r_fp_table[j]  <= PW'(j);
            end
            for (int i = 0; i < COMMIT_NUM; i++) begin
                r_int_rel_id[i] <= '0;
                r_fp_rel_id[i]  <= '0;
            end
            r_int_rel_vld <= '0;
            r_fp_rel_vld  <= '0;
            r_cancel_d    <= 1'b0;
            r_cancel_edge <= 1'b0;
        end else begin
            for (int j = 0; j < ARCH_ENTRY_NUM; j++) begin
                r_int_table[j] <= w_int_next[j];
                r_fp_table[j]  <= w_fp_next[j];
            end
            for (int i = 0; i < COMMIT_NUM; i++) begin
                r_int_rel_id[i] <= w_int_rel[i];
                r_fp_rel_id[i]  <= w_fp_rel[i];
            end
            r_int_rel_vld <= w_int_en;
            r_fp_rel_vld  <= v_fp_commit_en;
            r_cancel_d    <= cancel_en;
            r_cancel_edge <= cancel_en && !r_cancel_d;
        end
    end

    assign v_int_release_vld = r_int_rel_vld;
    assign v_fp_release_vld  = r_fp_rel_vld;
    assign cancel_edge_en_d  = r_cancel_edge;

endmodule

// File: doc/toy_commit_regfile.md
TOY_COMMIT_REGFILE -- requirements
Module: toy_commit_regfile

Interface
REQ-001 SHALL take parameter COMMIT_NUM, default 4, meaning commit slots per cycle (slot 0 oldest).
REQ-002 SHALL take parameter ARCH_ENTRY_NUM, default 32, meaning architectural registers per file (int, fp).
REQ-003 SHALL take parameter PHY_REG_ID_WIDTH, default 7, meaning physical register id width.
REQ-004 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port v_int_commit_en  in  COMMIT_NUM  per slot, commits an int rd mapping.
REQ-007 SHALL have port v_fp_commit_en  in  COMMIT_NUM  per slot, commits an fp rd mapping.
REQ-008 SHALL have port v_commit_rd_index  in  5 x COMMIT_NUM  architectural rd index per slot.
REQ-009 SHALL have port v_int_commit_phy_id  in  PHY_REG_ID_WIDTH x COMMIT_NUM  new int physical id per slot.
REQ-010 SHALL have port v_fp_commit_phy_id  in  PHY_REG_ID_WIDTH x COMMIT_NUM  new fp physical id per slot.
REQ-011 SHALL have port cancel_en  in  1  level flush request from the ROB.
REQ-012 SHALL have port v_int_backup_phy_id  out  PHY_REG_ID_WIDTH x ARCH_ENTRY_NUM  committed int map, one id per arch entry.
REQ-013 SHALL have port v_fp_backup_phy_id  out  PHY_REG_ID_WIDTH x ARCH_ENTRY_NUM  committed fp map, one id per arch entry.
REQ-014 SHALL have port cancel_edge_en_d  out  1  one-cycle restore pulse for the speculative rename table.
REQ-015 SHALL have ports v_int_release_vld / v_fp_release_vld  out  COMMIT_NUM  per slot, old id freed.
REQ-016 SHALL have ports v_int_release_id / v_fp_release_id  out  PHY_REG_ID_WIDTH x COMMIT_NUM  freed old physical id per slot.

Function
REQ-017 SHALL hold two register tables, int and fp, of ARCH_ENTRY_NUM entries each; backup outputs SHALL be the table registers driven directly.
REQ-018 On a rising edge with slot i enabled (int or fp), the entry at v_commit_rd_index[i] in that file SHALL take slot i's phy id.
REQ-019 When several enabled slots of the same file target the same index in one cycle, the highest-numbered slot SHALL win.
REQ-020 An int commit with index 0 SHALL be ignored: no table update, no release.
REQ-021 The release id for slot i SHALL be the prior mapping of its index: the phy id of the highest enabled slot k<i of the same file and index in the same cycle, else the table value at the start of the cycle.
REQ-022 Release outputs SHALL be registered, valid exactly one cycle after the commit.
REQ-023 v_*_release_vld[i] SHALL equal the registered commit enable for slot i (after the REQ-020 mask); release ids SHALL be don't-care when vld=0.
REQ-024 A slot with both int and fp enables set SHALL update both files independently.
REQ-025 cancel_edge_en_d SHALL pulse for one cycle on the edge after the first cycle of cancel_en high (rising edge of cancel_en only); a held cancel_en SHALL produce exactly one pulse.
REQ-026 Commits in the same cycle as cancel_en rising SHALL be applied, so backup outputs already include them while cancel_edge_en_d is high.
REQ-027 Table updates and releases SHALL continue normally while cancel_en is high.

Reset
REQ-028 While rst is high at a rising edge: int entry j SHALL reset to j, fp entry j to j.
REQ-029 While rst is high at a rising edge: all release_vld and cancel_edge_en_d SHALL reset to 0, and the cancel edge history SHALL reset to 0.
REQ-030 Commits presented during reset SHALL be discarded.
REQ-031 A cancel_en held high across reset deassertion SHALL produce a pulse one cycle after reset drops.

Verification
REQ-032 Reset, then idle -> v_int_backup_phy_id[5]=5, v_fp_backup_phy_id[31]=31, all release_vld=0, cancel_edge_en_d=0.
REQ-033 Int commit: slot 1 index 3 id 40 -> next cycle: int entry 3=40, int_release_vld=4'b0010, int_release_id[1]=3.
REQ-034 Same-index chain: slots 0,1,3 int commit index 7 with ids 50,51,53 -> next cycle: entry 7=53; release ids 7, 50, 51 on slots 0, 1, 3.
REQ-035 x0 commit: int slot 0 index 0 id 60, fp slot 0 index 0 id 61 -> int entry 0 stays 0 with int_release_vld[0]=0; fp entry 0=61 with fp_release_id[0]=0.
REQ-036 Cancel: cancel_en high 3 cycles plus int slot 2 index 9 id 70 in its first cycle -> exactly one cancel_edge_en_d pulse, in the following cycle, with int entry 9=70 at that time.
